imem_fetch_port: RTL and testbench
==================================

# imem_fetch_port

Parametrised, synchronous-read instruction memory for the RISC-V core. It serves instruction fetches through a request/ready/valid handshake with one-cycle latency and flags misaligned or out-of-range PCs. A byte-enabled load port lets a loader or debug block write the program image at run time. An optional reset-time clear sequencer zeroes the array one word per cycle.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 16 to 65536.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = keep contents.
- INIT_FILE, "": hex image loaded with $readmemh at time zero when non-empty. A reset with CLEAR_ON_RESET=1 wipes it.
- NOP_WORD, 32'h00000013: instruction returned on any fetch error.

Ports:
- SYS_clk  in  1  single clock; all logic on rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_pc  in  32  byte address of the instruction.
- fetch_ready  out  1  fetch can be accepted this cycle.
- fetch_valid  out  1  one-cycle pulse; response data valid.
- fetch_instr  out  32  fetched word.
- fetch_err  out  2  00 ok, 01 misaligned, 10 out of range.
- load_en  in  1  write request.
- load_addr  in  32  byte address; bits [1:0] ignored.
- load_data  in  32  write data, little-endian lanes.
- load_be  in  4  byte enables; bit i selects load_data[8i+7:8i].
- load_err  out  1  one-cycle pulse; previous-cycle load was out of range.
- init_done  out  1  high in the READY state.

## Operation
- Word index = addr >> 2, truncated to $clog2(DEPTH) bits only after the range check. A PC is in range when (addr >> 2) < DEPTH.
- States:
  - CLEAR: counter clr_idx writes 0 to mem[clr_idx] each edge. After writing DEPTH-1 the block moves to READY.
  - READY: normal operation.
- SYS_reset: the next state is CLEAR if CLEAR_ON_RESET=1, otherwise READY. clr_idx is set to 0.
- fetch_ready = !SYS_reset && state==READY && !load_en. A load has priority over a fetch in the same cycle.
- Fetch accept: fetch_req && fetch_ready at an edge. The block registers the response for the following cycle:
  - Aligned and in range: fetch_instr = mem[idx], fetch_err = 00.
  - pc[1:0] != 0: fetch_instr = NOP_WORD, fetch_err = 01. Misalignment takes priority over range.
  - Out of range: fetch_instr = NOP_WORD, fetch_err = 10.
- Without an accept, fetch_valid = 0 next cycle. fetch_instr and fetch_err hold their last values.
- Load, accepted only in READY:
  - In range: write the enabled bytes at the edge. load_be = 0 writes nothing and is not an error.
  - Out of range: no write; load_err pulses the next cycle.
  - In CLEAR: load_en is ignored silently, with no write and no load_err.
- Read-after-write: a fetch accepted in the cycle after a load to the same word returns the new data.

## Timing
- Reset values, in the cycle after the reset edge: fetch_valid 0, fetch_instr 0, fetch_err 00, load_err 0.
- fetch_ready is 0 while SYS_reset is high. init_done is 0 if CLEAR_ON_RESET=1, or 1 if CLEAR_ON_RESET=0.
- Clear duration: reset is sampled low at edge E0. Edges E0 through E(DEPTH-1) write words 0 through DEPTH-1. init_done and fetch_ready (absent a load) are high from the cycle after E(DEPTH-1).
- Fetch latency is exactly 1 cycle. Throughput is one fetch per cycle, with no bubbles between back-to-back accepts.
- Reset mid-operation: a response scheduled for the next cycle is dropped (fetch_valid = 0). A clear in progress restarts at index 0.
- Outputs are registered, except fetch_ready and init_done, which decode from state, load_en and SYS_reset.

## Test plan
- Clear: DEPTH=16, CLEAR_ON_RESET=1, pre-loaded nonzero image. After reset, init_done rises exactly 16 cycles after reset deassertion. Fetches of PC 0x0 to 0x3C all return 0 with err 00.
- Load/fetch: load 0xDEADBEEF at 0x8 with be=4'hF, then be=4'b0010 with data 0x0000AA00. Fetching 0x8 in the next cycle returns 0xDEADAAEF, valid exactly 1 cycle after accept.
- Back-to-back: fetch_req held high with PC 0x0, 0x4, 0x8 on consecutive cycles. Three consecutive valid pulses carry mem[0], mem[1], mem[2] in order.
- Errors (DEPTH=16):
  - PC 0x6 returns 0x00000013, err 01.
  - PC 0x40 returns 0x00000013, err 10.
  - PC 0x42 returns err 01.
  - Load to 0x40 pulses load_err and leaves memory unchanged.
- Contention: load_en and fetch_req both high. fetch_ready is 0, the write occurs, and no fetch_valid follows. The fetch is accepted the next cycle with the new data.
- Reset mid-fetch and mid-clear: reset asserted in the accept cycle gives no valid pulse. Reset at clr_idx=7 restarts the clear, and init_done rises DEPTH cycles after release.

Source files
------------

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - synchronous-read instruction memory with fetch port, byte-enabled load port and reset-time clear
// One-cycle fetch latency; loads win over fetches in the same cycle.
module imem_fetch_port #(
   parameter int          DEPTH          = 1024,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter              INIT_FILE      = "",
   parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
   input  logic        SYS_clk,
   input  logic        SYS_reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic        fetch_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_instr,
   output logic [1:0]  fetch_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic [3:0]  load_be,
   output logic        load_err,
   output logic        init_done
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_idx, clr_idx_nxt;
   logic [31:0]   mem [DEPTH];

   logic          fetch_misaligned, fetch_in_range, fetch_accept;
   logic          load_in_range, load_accept, clr_we;
   logic [AW-1:0] fetch_idx, load_idx;
   logic          unused_load_lsb;

   // Range is checked on the full word index before truncation to AW bits.
   assign fetch_misaligned = |fetch_pc[1:0];
   assign fetch_in_range   = ~|fetch_pc[31:AW+2];
   assign load_in_range    = ~|load_addr[31:AW+2];
   assign fetch_idx        = fetch_pc[AW+1:2];
   assign load_idx         = load_addr[AW+1:2];
   assign unused_load_lsb  = ^load_addr[1:0];

   assign fetch_ready  = !SYS_reset && (state == S_READY) && !load_en;
   assign init_done    = (state == S_READY);
   assign fetch_accept = fetch_req && fetch_ready;
   assign load_accept  = load_en && !SYS_reset && (state == S_READY);
   assign clr_we       = !SYS_reset && (state == S_CLEAR);

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      if (state == S_CLEAR) begin
         clr_idx_nxt = clr_idx + 1'b1;
         if (clr_idx == LAST_IDX) state_nxt = S_READY;
      end
   end

   always_ff @(posedge SYS_clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (load_accept && load_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (load_be[b]) mem[load_idx][8*b +: 8] <= load_data[8*b +: 8];
         end
      end
   end

   // Misalignment is reported ahead of range when both apply.
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         fetch_valid <= 1'b0;
         fetch_instr <= '0;
         fetch_err   <= 2'b00;
         load_err    <= 1'b0;
      end else begin
         fetch_valid <= fetch_accept;
         load_err    <= load_accept && !load_in_range;
         if (fetch_accept) begin
            if (fetch_misaligned) begin
               fetch_instr <= NOP_WORD;
               fetch_err   <= 2'b01;
            end else if (!fetch_in_range) begin
               fetch_instr <= NOP_WORD;
               fetch_err   <= 2'b10;
            end else begin
               fetch_instr <= mem[fetch_idx];
               fetch_err   <= 2'b00;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - directed vector bench for imem_fetch_port
// DEPTH=16 with clear-on-reset; inputs driven and outputs sampled 1ns after each rising edge.
module tb_imem_fetch_port;

   logic        SYS_clk = 1'b0;
   logic        SYS_reset = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        fetch_ready, fetch_valid;
   logic [31:0] fetch_instr;
   logic [1:0]  fetch_err;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
   logic [3:0]  load_be = '0;
   logic        load_err, init_done;

   int n_vec = 0;
   int n_bad = 0;

   imem_fetch_port #(
      .DEPTH(16), .CLEAR_ON_RESET(1'b1), .INIT_FILE(""), .NOP_WORD(32'h00000013)
   ) dut (
      .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_be(load_be),
      .load_err(load_err), .init_done(init_done)
   );

   always #5 SYS_clk = ~SYS_clk;

   typedef struct packed {
      logic        is_load;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_instr;
      logic [1:0]  exp_err;
      logic        exp_lerr;
   } vec_t;

   vec_t vecs [14];

   task automatic step();
      @(posedge SYS_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;

      vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF,    32'h0,        2'b00, 1'b0};
      vecs[1]  = '{1'b1, 32'h08, 32'h0000AA00, 4'b0010, 32'h0,        2'b00, 1'b0};
      vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'h0,    32'hDEADAAEF, 2'b00, 1'b0};
      vecs[3]  = '{1'b0, 32'h06, 32'h0,        4'h0,    32'h00000013, 2'b01, 1'b0};
      vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0,    32'h00000013, 2'b10, 1'b0};
      vecs[5]  = '{1'b0, 32'h42, 32'h0,        4'h0,    32'h00000013, 2'b01, 1'b0};
      vecs[6]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b00, 1'b1};
      vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0,    32'h0,        2'b00, 1'b0};
      vecs[8]  = '{1'b1, 32'h04, 32'h11223344, 4'b1001, 32'h0,        2'b00, 1'b0};
      vecs[9]  = '{1'b0, 32'h04, 32'h0,        4'h0,    32'h11000044, 2'b00, 1'b0};
      vecs[10] = '{1'b1, 32'h0C, 32'h55667788, 4'h0,    32'h0,        2'b00, 1'b0};
      vecs[11] = '{1'b0, 32'h0C, 32'h0,        4'h0,    32'h0,        2'b00, 1'b0};
      vecs[12] = '{1'b1, 32'h3F, 32'hA5A5A5A5, 4'hF,    32'h0,        2'b00, 1'b0};
      vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'h0,    32'hA5A5A5A5, 2'b00, 1'b0};

      // Reset values and first clear
      step();
      step();
      chk("rst_outputs", {fetch_valid, fetch_instr, fetch_err, load_err}, 36'h0);
      chk("rst_ready_init", {fetch_ready, init_done}, 2'b00);
      SYS_reset = 1'b0;
      wait_init(n);
      chk("clear_cycles", n, 16);
      chk("ready_after_clear", fetch_ready, 1'b1);

      // Table-driven loads and fetches, issued back to back
      for (int i = 0; i < 14; i++) begin
         load_en   = vecs[i].is_load;
         fetch_req = !vecs[i].is_load;
         load_addr = vecs[i].addr;
         fetch_pc  = vecs[i].addr;
         load_data = vecs[i].data;
         load_be   = vecs[i].be;
         step();
         if (vecs[i].is_load)
            chk($sformatf("vec%0d_load", i), {fetch_valid, load_err}, {1'b0, vecs[i].exp_lerr});
         else
            chk($sformatf("vec%0d_fetch", i), {fetch_valid, load_err, fetch_err, fetch_instr},
                {1'b1, 1'b0, vecs[i].exp_err, vecs[i].exp_instr});
      end
      load_en = 1'b0;
      fetch_req = 1'b0;
      step();
      chk("idle_no_valid", {fetch_valid, load_err, fetch_instr}, {2'b00, 32'hA5A5A5A5});

      // Contention: load wins, fetch accepted the following cycle with new data
      load_en = 1'b1; load_addr = 32'h10; load_data = 32'h12345678; load_be = 4'hF;
      fetch_req = 1'b1; fetch_pc = 32'h10;
      #1;
      chk("contend_ready", fetch_ready, 1'b0);
      step();
      chk("contend_no_valid", fetch_valid, 1'b0);
      load_en = 1'b0;
      #1;
      chk("contend_ready2", fetch_ready, 1'b1);
      step();
      chk("contend_fetch", {fetch_valid, fetch_err, fetch_instr}, {1'b1, 2'b00, 32'h12345678});

      // Back-to-back fetches
      fetch_pc = 32'h0;
      step();
      chk("b2b_0", {fetch_valid, fetch_instr}, {1'b1, 32'h0});
      fetch_pc = 32'h4;
      step();
      chk("b2b_1", {fetch_valid, fetch_instr}, {1'b1, 32'h11000044});
      fetch_pc = 32'h8;
      step();
      chk("b2b_2", {fetch_valid, fetch_instr}, {1'b1, 32'hDEADAAEF});
      fetch_req = 1'b0;
      step();
      chk("b2b_end", {fetch_valid, fetch_instr}, {1'b0, 32'hDEADAAEF});

      // Fill nonzero image
      load_en = 1'b1; load_be = 4'hF;
      for (int i = 0; i < 16; i++) begin
         load_addr = 32'(i * 4);
         load_data = 32'hC0DE0000 | 32'(i + 1);
         step();
      end
      load_en = 1'b0;

      // Reset in the accept cycle drops the response
      fetch_req = 1'b1; fetch_pc = 32'h8; SYS_reset = 1'b1;
      #1;
      chk("rst_fetch_ready", fetch_ready, 1'b0);
      step();
      chk("rst_fetch_drop", {fetch_valid, fetch_instr, init_done}, {1'b0, 32'h0, 1'b0});
      fetch_req = 1'b0;
      SYS_reset = 1'b0;

      // Reset at clr_idx=7 restarts the clear
      for (int i = 0; i < 7; i++) step();
      chk("mid_clear_busy", init_done, 1'b0);
      SYS_reset = 1'b1;
      step();
      SYS_reset = 1'b0;
      wait_init(n);
      chk("restart_clear_cycles", n, 16);

      fetch_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         fetch_pc = 32'(i * 4);
         step();
         chk($sformatf("cleared_word%0d", i), {fetch_valid, fetch_err, fetch_instr}, {1'b1, 2'b00, 32'h0});
      end
      fetch_req = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
